// File: rtl/video_timing_regen.sv
// Regenerates VBlank from raw HSync/VSync, measures frame geometry and derives an adaptive
// vertical aspect value. A frame-length lock indicator reports a stable input timing.
module video_timing_regen #(
    parameter int unsigned TOP_LINES    = 34,
    parameter int unsigned BOTTOM_LINES = 25,
    parameter int unsigned MIN_LINES    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hs,
    input  logic       vs,
    input  logic       vb_in,
    input  logic       orig_vbl,
    output logic       vblank,
    output logic [7:0] ary,
    output logic [8:0] total_lines,
    output logic [8:0] visible_lines,
    output logic       locked
);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_st_e;

    localparam logic [8:0] TopLines    = 9'(TOP_LINES);
    localparam logic [8:0] BottomLines = 9'(BOTTOM_LINES);
    localparam logic [8:0] MinLines    = 9'(MIN_LINES);
    localparam logic [8:0] CntMax      = 9'd511;

    logic       hs_q;
    logic       vs_q, vs_d;
    logic       vbl_gen_q, vbl_gen_d;
    logic       aligned_q, aligned_d;
    logic       prev_valid_q, prev_valid_d;
    logic [8:0] line_cnt_q, line_cnt_d;
    logic [8:0] vis_cnt_q, vis_cnt_d;
    logic [8:0] total_q, total_d;
    logic [8:0] visible_q, visible_d;
    logic [8:0] vbl_start_q, vbl_start_d;
    logic [7:0] ary_q, ary_d;
    lock_st_e   lock_st_q, lock_st_d;

    logic       line_ev;
    logic       frame_ev;
    logic       frame_valid;
    logic [7:0] vis_sat;
    logic [7:0] ary_calc;

    assign line_ev     = hs & ~hs_q;
    assign frame_ev    = line_ev & vs & ~vs_q;
    // The first frame edge after reset only aligns the counter; its length is meaningless.
    assign frame_valid = frame_ev & aligned_q & (line_cnt_q >= MinLines);
    assign vblank      = orig_vbl ? vb_in : vbl_gen_q;
    assign vis_sat     = (vis_cnt_q > 9'd255) ? 8'hFF : vis_cnt_q[7:0];
    // Max (255*9+8)>>4 = 143, so the result always fits in 8 bits.
    assign ary_calc    = 8'((12'(vis_sat) * 12'd9 + 12'd8) >> 4);

    assign ary           = ary_q;
    assign total_lines   = total_q;
    assign visible_lines = visible_q;
    assign locked        = (lock_st_q == StLocked);

    // Line and visible-line counters; a frame edge restarts both.
    always_comb begin
        line_cnt_d = line_cnt_q;
        vis_cnt_d  = vis_cnt_q;
        vs_d       = vs_q;
        if (line_ev) begin
            vs_d = vs;
        end
        if (frame_ev) begin
            line_cnt_d = '0;
            vis_cnt_d  = '0;
        end else if (line_ev) begin
            if (line_cnt_q != CntMax) begin
                line_cnt_d = line_cnt_q + 9'd1;
            end
            if (!vblank && vis_cnt_q != CntMax) begin
                vis_cnt_d = vis_cnt_q + 9'd1;
            end
        end
    end

    // Frame measurements latched only on frames long enough to be trusted.
    always_comb begin
        total_d     = total_q;
        visible_d   = visible_q;
        vbl_start_d = vbl_start_q;
        ary_d       = ary_q;
        aligned_d   = aligned_q | frame_ev;
        if (frame_valid) begin
            total_d     = line_cnt_q;
            visible_d   = vis_cnt_q;
            vbl_start_d = line_cnt_q - BottomLines;
            ary_d       = ary_calc;
        end
    end

    // Regenerated blank: set at vbl_start, cleared at TOP_LINES, clear wins on a tie.
    always_comb begin
        vbl_gen_d = vbl_gen_q;
        if (line_ev) begin
            if (line_cnt_q == TopLines) begin
                vbl_gen_d = 1'b0;
            end else if (line_cnt_q == vbl_start_q) begin
                vbl_gen_d = 1'b1;
            end
        end
    end

    // Lock FSM next state: lock needs two back-to-back valid frames of equal length.
    always_comb begin
        lock_st_d    = lock_st_q;
        prev_valid_d = prev_valid_q;
        if (frame_ev) begin
            if (frame_valid) begin
                prev_valid_d = 1'b1;
                unique case (lock_st_q)
                    StUnlocked: begin
                        if (prev_valid_q && line_cnt_q == total_q) begin
                            lock_st_d = StLocked;
                        end
                    end
                    StLocked: begin
                        if (line_cnt_q != total_q) begin
                            lock_st_d = StUnlocked;
                        end
                    end
                    default: lock_st_d = StUnlocked;
                endcase
            end else begin
                prev_valid_d = 1'b0;
                lock_st_d    = StUnlocked;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            vbl_gen_q    <= 1'b0;
            aligned_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            line_cnt_q   <= '0;
            vis_cnt_q    <= '0;
            total_q      <= 9'd262;
            visible_q    <= 9'd192;
            vbl_start_q  <= 9'd237;
            ary_q        <= 8'd108;
            lock_st_q    <= StUnlocked;
        end else begin
            hs_q         <= hs;
            vs_q         <= vs_d;
            vbl_gen_q    <= vbl_gen_d;
            aligned_q    <= aligned_d;
            prev_valid_q <= prev_valid_d;
            line_cnt_q   <= line_cnt_d;
            vis_cnt_q    <= vis_cnt_d;
            total_q      <= total_d;
            visible_q    <= visible_d;
            vbl_start_q  <= vbl_start_d;
            ary_q        <= ary_d;
            lock_st_q    <= lock_st_d;
        end
    end

endmodule

// File: tb/tb_video_timing_regen.sv
// Randomized bench for video_timing_regen: a frame-level model predicts outputs after every
// line edge, reset and orig_vbl change; a negedge monitor drains and compares the queue.
module tb_video_timing_regen;

    localparam int TopL = 34;
    localparam int BotL = 25;
    localparam int MinL = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic       vb_in = 1'b1;
    logic       orig_vbl = 1'b1;
    logic       vblank;
    logic [7:0] ary;
    logic [8:0] total_lines;
    logic [8:0] visible_lines;
    logic       locked;

    always #5 clk = ~clk;

    video_timing_regen #(
        .TOP_LINES   (TopL),
        .BOTTOM_LINES(BotL),
        .MIN_LINES   (MinL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hs           (hs),
        .vs           (vs),
        .vb_in        (vb_in),
        .orig_vbl     (orig_vbl),
        .vblank       (vblank),
        .ary          (ary),
        .total_lines  (total_lines),
        .visible_lines(visible_lines),
        .locked       (locked)
    );

    typedef struct {
        int         kind;  // 0 line edge, 1 reset, 2 orig_vbl change
        int         idx;
        logic       vbl;
        logic [8:0] tl;
        logic [8:0] vl;
        logic [7:0] ar;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   line_no = 0;

    // Reference model state: frame-level quantities only.
    int   m_cnt, m_vis, m_prev_len, m_total, m_visible, m_vbl_start, m_ary;
    bit   m_vs, m_vbl, m_aligned, m_locked;

    task automatic model_reset();
        m_cnt = 0; m_vis = 0; m_vs = 0; m_vbl = 0; m_aligned = 0; m_locked = 0;
        m_prev_len = -1; m_total = 262; m_visible = 192; m_vbl_start = 237; m_ary = 108;
    endtask

    // Predict the effect of one line edge carrying vs=v and vb_in=b.
    task automatic model_line(bit v, bit b);
        bit sel_blank;
        bit fe;
        sel_blank = orig_vbl ? b : m_vbl;
        fe = v && !m_vs;
        m_vs = v;
        if (m_cnt == TopL) m_vbl = 0;
        else if (m_cnt == m_vbl_start) m_vbl = 1;
        if (fe) begin
            if (m_aligned && m_cnt >= MinL) begin
                m_locked    = (m_prev_len == m_cnt);
                m_prev_len  = m_cnt;
                m_total     = m_cnt;
                m_visible   = m_vis;
                m_vbl_start = (m_cnt - BotL) & 511;
                m_ary       = ((m_vis > 255 ? 255 : m_vis) * 9 + 8) / 16;
            end else begin
                m_locked   = 0;
                m_prev_len = -1;
            end
            m_aligned = 1;
            m_cnt = 0;
            m_vis = 0;
        end else begin
            if (m_cnt < 511) m_cnt++;
            if (!sel_blank && m_vis < 511) m_vis++;
        end
    endtask

    function automatic exp_t snap(int kind);
        exp_t e;
        e.kind = kind;
        e.idx  = line_no;
        e.vbl  = orig_vbl ? vb_in : m_vbl;
        e.tl   = 9'(m_total);
        e.vl   = 9'(m_visible);
        e.ar   = 8'(m_ary);
        e.lk   = m_locked;
        return e;
    endfunction

    function automatic string kind_name(int k);
        case (k)
            0:       return "line";
            1:       return "reset";
            default: return "orig_vbl";
        endcase
    endfunction

    task automatic chk(string nm, int kind, int idx, logic [8:0] act, logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s after %s #%0d: got %0d, expected %0d", nm, kind_name(kind), idx,
                     act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("vblank", e.kind, e.idx, {8'd0, vblank}, {8'd0, e.vbl});
            chk("total_lines", e.kind, e.idx, total_lines, e.tl);
            chk("visible_lines", e.kind, e.idx, visible_lines, e.vl);
            chk("ary", e.kind, e.idx, {1'b0, ary}, {1'b0, e.ar});
            chk("locked", e.kind, e.idx, {8'd0, locked}, {8'd0, e.lk});
        end
    end

    function automatic int rgap();
        return int'($urandom_range(2, 1));
    endfunction

    // Called at posedge+2; returns at posedge+2 with hs low for at least one edge.
    task automatic send_line(bit v, bit b);
        hs = 1'b1; vs = v; vb_in = b;
        model_line(v, b);
        line_no++;
        @(posedge clk); #1;
        sb.push_back(snap(0));
        #1; hs = 1'b0;
        repeat (rgap()) @(posedge clk);
        #2;
    endtask

    // Frame edge followed by n counted lines; vb_in low on counted lines lo..hi.
    task automatic send_frame(int n, int lo, int hi, bit noisy);
        bit b;
        send_line(1'b1, 1'b1);
        for (int k = 1; k <= n; k++) begin
            b = noisy ? 1'($urandom_range(1, 0)) : ((k >= lo && k <= hi) ? 1'b0 : 1'b1);
            send_line(1'b0, b);
        end
    endtask

    task automatic do_reset(int cycles);
        reset_n = 1'b0; hs = 1'b0; vs = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        sb.push_back(snap(1));
        #1; reset_n = 1'b1;
    endtask

    task automatic set_orig(bit o, bit b);
        orig_vbl = o; vb_in = b;
        #1;
        sb.push_back(snap(2));
        @(posedge clk); #2;
    endtask

    initial begin
        int len;
        int lo;
        model_reset();
        do_reset(2);
        @(posedge clk); #2;

        // Nominal 262-line timing with the core's own blank: align, latch, then lock.
        repeat (3) send_frame(262, 40, 231, 1'b0);

        // Output mux follows orig_vbl in the same cycle.
        set_orig(1'b0, 1'b1);
        set_orig(1'b1, 1'b0);
        set_orig(1'b0, 1'b0);

        // Regenerated blank drives the output and the visible count.
        repeat (2) send_frame(262, 40, 231, 1'b0);
        set_orig(1'b1, 1'b1);

        // Length change: unlock, then relock on the repeat.
        repeat (2) begin
            lo = int'($urandom_range(40, 10));
            send_frame(312, lo, lo + int'($urandom_range(250, 150)), 1'b0);
        end

        // Runt frame is ignored but drops lock.
        send_frame(40, 5, 30, 1'b0);

        // Long frame saturates the line counter.
        send_frame(600, 20, 300, 1'b0);

        // Random lengths and random blanking, each length repeated to lock.
        repeat (3) begin
            len = int'($urandom_range(300, 50));
            repeat (2) send_frame(len, 0, 0, 1'b1);
        end

        // Mid-frame reset pulse: partial frame discarded, first edge after release invalid.
        send_frame(262, 40, 231, 1'b0);
        send_line(1'b1, 1'b1);
        for (int k = 0; k < 100; k++) send_line(1'b0, 1'b0);
        do_reset(1);
        @(posedge clk); #2;
        repeat (3) send_frame(262, 40, 231, 1'b0);
        send_line(1'b1, 1'b1);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_regen.md
VIDEO_TIMING_REGEN -- requirements
Module: video_timing_regen

Interface
REQ-001 SHALL have parameter TOP_LINES, default 34: line index at which the regenerated VBlank ends.
REQ-002 SHALL have parameter BOTTOM_LINES, default 25: number of lines before the frame end at which the regenerated VBlank starts.
REQ-003 SHALL have parameter MIN_LINES, default 64: the minimum frame length, in lines, that counts as valid.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port hs, input, 1 bit: raw HSync from the console core, active high.
REQ-007 SHALL have port vs, input, 1 bit: raw VSync from the console core, active high.
REQ-008 SHALL have port vb_in, input, 1 bit: the core's original VBlank.
REQ-009 SHALL have port orig_vbl, input, 1 bit: 1 selects vb_in as the output blank, 0 selects the regenerated blank.
REQ-010 SHALL have port vblank, output, 1 bit: the selected VBlank.
REQ-011 SHALL have port ary, output, 8 bits: the adaptive vertical aspect value.
REQ-012 SHALL have port total_lines, output, 9 bits: the length of the last valid frame.
REQ-013 SHALL have port visible_lines, output, 9 bits: the non-blanked line count of the last valid frame.
REQ-014 SHALL have port locked, output, 1 bit: frame length has been stable for two consecutive valid frames.

Function
REQ-015 SHALL register hs every clk; a line event occurs in the cycle where registered hs is 0 and hs is 1.
REQ-016 SHALL sample vs only on line events; a frame event is a line event where the previous sampled vs is 0 and the current vs is 1.
REQ-017 SHALL, on each non-frame line event, increment line_cnt (9 bits), saturating at 511.
REQ-018 SHALL, on each line event, increment vis_cnt (9 bits), saturating at 511, when the selected vblank is 0.
REQ-019 SHALL, on a frame event, reset line_cnt and vis_cnt to 0 in the same cycle; a frame event takes priority over increments.
REQ-020 SHALL treat a frame event with line_cnt >= MIN_LINES as a valid frame, which latches four values in the same cycle:
 - total_lines <= line_cnt;
 - visible_lines <= vis_cnt;
 - vbl_start <= line_cnt - BOTTOM_LINES;
 - ary <= (min(vis_cnt,255)*9 + 8) >> 4.
 Range check: vis_cnt 255 gives 143 (8'h8F); vis_cnt 0 gives 0.
REQ-021 SHALL, on an invalid frame event (line_cnt < MIN_LINES), still reset the counters, leave every latched value and ary unchanged, and clear locked.
REQ-022 SHALL drive locked through a two-state lock FSM:
 - UNLOCKED to LOCKED when two successive valid frames have an equal total_lines.
 - LOCKED to UNLOCKED on any valid frame whose length differs from the held total_lines, or on any invalid frame.
REQ-023 SHALL set the regenerated blank vbl_gen to 1 on a line event with line_cnt == vbl_start, and clear it to 0 on a line event with line_cnt == TOP_LINES.
REQ-024 SHALL apply clear priority if vbl_start == TOP_LINES.
REQ-025 SHALL keep vbl_gen unchanged between line events.
REQ-026 SHALL drive vblank = orig_vbl ? vb_in : vbl_gen combinationally, so an orig_vbl change takes effect in the same cycle.
REQ-027 SHALL handle hs and vs rising in the same clk cycle as a single frame event.
REQ-028 SHALL hold counters during a period with no line events; there is no timeout.

Reset
REQ-029 SHALL, with reset_n = 0 at a clk edge, set:
 - line_cnt = 0 and vis_cnt = 0;
 - registered hs = 0 and sampled vs = 0;
 - vbl_gen = 0 and locked = 0 (FSM UNLOCKED);
 - total_lines = 262 and vbl_start = 237;
 - visible_lines = 192 and ary = 108 (8'd108).
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; the first frame event after release starts counting from 0 and is always treated as invalid (counter not yet aligned).

Verification
REQ-031 SHALL cover: 262-line frames (vs at line 0) with vb_in = 0 on lines 40-231 -> after the second valid frame total_lines = 262, visible_lines = 192, ary = 108, locked = 1 on the next valid frame.
REQ-032 SHALL cover: orig_vbl = 0 with 262-line frames -> vblank rises at line 237 and falls at line 34.
REQ-033 SHALL cover: after lock, one frame of 312 lines -> locked = 0 and total_lines = 312; locked = 1 again after the following 312-line frame.
REQ-034 SHALL cover: a 40-line runt frame (vs pulse early) -> total_lines, ary and visible_lines unchanged, and locked = 0.
REQ-035 SHALL cover: 600 lines with no vs -> line_cnt saturates at 511; the next frame event latches total_lines = 511.
REQ-036 SHALL cover: reset_n pulsed low mid-frame for 1 cycle -> all outputs at reset values next cycle; the first subsequent frame is invalid, and the second updates the outputs.
